// File: rtl/cnn_pkg.sv
// Shared constants and types for the fully connected layer datapath.
package cnn_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int OUTPUT_NEURONS = 32;
  localparam int CNT_W          = $clog2(OUTPUT_NEURONS);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fc_vector_packer.sv
// Packs the serial one-neuron-per-cycle MAC output into the wide input_fc vector
// for the activation stage, double-buffered behind a valid/ready output register.
module fc_vector_packer #(
  parameter int DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
  parameter int OUTPUT_NEURONS = cnn_pkg::OUTPUT_NEURONS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] output_fc,
  output logic                                 len_err
);
  import cnn_pkg::*;

  localparam int VEC_W = DATA_WIDTH * OUTPUT_NEURONS;
  localparam int IDX_W = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NEURONS - 1);

  fill_state_e               r_state;
  logic [IDX_W-1:0]          r_cnt;
  logic [VEC_W-1:0]          r_fill;
  logic [VEC_W-1:0]          r_out;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_len_err;

  logic                      w_accept;
  logic                      w_at_last;
  logic                      w_slot_free;
  logic                      w_complete;
  logic                      w_transfer;
  logic [OUTPUT_NEURONS-1:0] w_lane_we;
  logic [VEC_W-1:0]          w_fill_next;

  assign w_accept    = in_valid && r_in_ready;
  assign w_at_last   = (r_cnt == LAST_IDX);
  assign w_slot_free = !r_out_valid || out_ready;
  // A complete vector is either finishing on this edge or already parked in HOLD.
  assign w_complete  = (w_accept && w_at_last) || (r_state == HOLD);
  assign w_transfer  = w_complete && w_slot_free;

  // The fill view including this edge's element lets the final lane bypass
  // straight into the output register without an extra cycle.
  generate
    for (genvar gi = 0; gi < OUTPUT_NEURONS; gi++) begin : g_lane
      assign w_lane_we[gi] = w_accept && (r_cnt == IDX_W'(gi));
      assign w_fill_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        w_lane_we[gi] ? in_data : r_fill[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_fill      <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_fill    <= w_fill_next;
      r_len_err <= w_accept && (in_last != w_at_last);
      if (w_transfer) begin
        r_out       <= w_fill_next;
        r_out_valid <= 1'b1;
        r_cnt       <= '0;
        r_state     <= FILL;
        r_in_ready  <= 1'b1;
      end else begin
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_complete) begin
          r_state    <= HOLD;
          r_in_ready <= 1'b0;
        end else begin
          r_state    <= FILL;
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign output_fc = r_out;
  assign len_err   = r_len_err;

endmodule
